// File: rtl/karat_div.sv
// karat_div: iterative radix-2 restoring divider for unsigned operands.
//
// One quotient bit is produced per clock. A request is accepted in IDLE,
// wI steps run in BUSY, and the result is held in DONE until the consumer
// takes it. A zero divisor skips the iteration: the result (all-ones
// quotient, remainder equal to the dividend) is presented one cycle after
// accept and oDivZero is raised.
//
// Ports
//   iClk      clock, rising edge active
//   iRst_n    asynchronous active-low reset
//   iValid    request valid (iX/iY presented)
//   oReady    request accepted this cycle (high only in IDLE)
//   iX, iY    dividend, divisor (unsigned, wI bits)
//   oValid    result valid (high only in DONE)
//   iReady    consumer takes the result
//   oQ, oR    quotient, remainder
//   oDivZero  result comes from a zero divisor
module karat_div #(
    parameter int wI = 64,
    parameter int wC = $clog2(wI) + 1
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iValid,
    output logic          oReady,
    input  logic [wI-1:0] iX,
    input  logic [wI-1:0] iY,
    output logic          oValid,
    input  logic          iReady,
    output logic [wI-1:0] oQ,
    output logic [wI-1:0] oR,
    output logic          oDivZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [wC-1:0] LAST_STEP = wC'(wI - 1);

    state_t          state_q;
    state_t          state_d;
    logic [wI:0]     rem_q;     // partial remainder, one guard bit wide
    logic [wI-1:0]   quo_q;     // dividend shifts out, quotient shifts in
    logic [wI-1:0]   div_q;
    logic [wC-1:0]   cnt_q;
    logic            dz_q;

    // One restoring step. The compare and subtract run at wI+1 bits so the
    // bit shifted out of the top of the remainder is not lost when the
    // divisor is at or above 2^(wI-1). Returns {next_rem, next_quo}.
    function automatic logic [2*wI:0] div_step(
        input logic [wI:0]   rem,
        input logic [wI-1:0] quo,
        input logic [wI-1:0] dvs
    );
        logic [wI:0] sh;
        logic [wI:0] dvs_x;
        sh    = (rem << 1) | {{wI{1'b0}}, quo[wI-1]};
        dvs_x = {1'b0, dvs};
        if (sh >= dvs_x) begin
            return {sh - dvs_x, quo[wI-2:0], 1'b1};
        end
        return {sh, quo[wI-2:0], 1'b0};
    endfunction

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (iValid) state_d = BUSY;
            // A zero-divisor request spends exactly one cycle here.
            BUSY: if (dz_q || cnt_q == LAST_STEP) state_d = DONE;
            DONE: if (iReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (iValid) begin
                        div_q <= iY;
                        cnt_q <= '0;
                        if (iY == '0) begin
                            dz_q  <= 1'b1;
                            quo_q <= '1;
                            rem_q <= {1'b0, iX};
                        end else begin
                            dz_q  <= 1'b0;
                            quo_q <= iX;
                            rem_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (!dz_q) begin
                        {rem_q, quo_q} <= div_step(rem_q, quo_q, div_q);
                        cnt_q          <= cnt_q + wC'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The remainder never exceeds the divisor, so its guard bit is always
    // zero once a step completes.
    assign oReady   = (state_q == IDLE);
    assign oValid   = (state_q == DONE);
    assign oQ       = quo_q;
    assign oR       = rem_q[wI-1:0];
    assign oDivZero = dz_q;

endmodule

// File: tb/tb_karat_div.sv
// tb_karat_div: bench for karat_div. An 8-bit instance runs the directed
// cases (latency, boundaries, zero divisor, backpressure, reset abort);
// a 64-bit instance runs random back-to-back requests. Expected results
// are queued at accept and compared when the result handshake happens.
module tb_karat_div;

    localparam int N_RAND = 500;

    logic clk;
    logic rst_n;

    logic       iv8, ordy8, ov8, rdy8, dz8;
    logic [7:0] x8, y8, q8, r8;

    logic        iv64, ordy64, ov64, rdy64, dz64;
    logic [63:0] x64, y64, q64, r64;

    karat_div #(.wI(8)) dut8 (
        .iClk    (clk),
        .iRst_n  (rst_n),
        .iValid  (iv8),
        .oReady  (ordy8),
        .iX      (x8),
        .iY      (y8),
        .oValid  (ov8),
        .iReady  (rdy8),
        .oQ      (q8),
        .oR      (r8),
        .oDivZero(dz8)
    );

    karat_div #(.wI(64)) dut64 (
        .iClk    (clk),
        .iRst_n  (rst_n),
        .iValid  (iv64),
        .oReady  (ordy64),
        .iX      (x64),
        .iY      (y64),
        .oValid  (ov64),
        .iReady  (rdy64),
        .oQ      (q64),
        .oR      (r64),
        .oDivZero(dz64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb8[$];
    exp_t sb64[$];

    // 8-bit monitor: push on accept, check latency on oValid rise,
    // pop and compare on result handshake.
    int   acc_cyc8 = 0;
    logic v8_prev  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            v8_prev = 1'b0;
        end else begin
            if (ov8 && !v8_prev) begin
                check_eq("pending8", 128'(sb8.size() != 0), 128'd1);
                if (sb8.size() != 0)
                    check_eq("latency8", 128'(cyc - acc_cyc8), 128'(sb8[0].lat));
            end
            if (ov8 && rdy8) begin
                check_eq("result8_pending", 128'(sb8.size() != 0), 128'd1);
                if (sb8.size() != 0) begin
                    e = sb8.pop_front();
                    check_eq("q8", 128'(q8), 128'(e.q));
                    check_eq("r8", 128'(r8), 128'(e.r));
                    check_eq("dz8", 128'(dz8), 128'(e.dz));
                end
            end
            if (iv8 && ordy8) begin
                e.x   = 64'(x8);
                e.y   = 64'(y8);
                e.dz  = (y8 == 8'd0);
                e.q   = (y8 == 8'd0) ? 64'hFF : 64'(x8 / y8);
                e.r   = (y8 == 8'd0) ? 64'(x8) : 64'(x8 % y8);
                e.lat = (y8 == 8'd0) ? 1 : 8;
                sb8.push_back(e);
                acc_cyc8 = cyc + 1;
            end
            v8_prev = ov8;
        end
    end

    // 64-bit monitor: scoreboard compare plus the division identity.
    always @(negedge clk) begin
        exp_t e;
        logic [127:0] recon;
        if (rst_n) begin
            if (ov64 && rdy64) begin
                check_eq("result64_pending", 128'(sb64.size() != 0), 128'd1);
                if (sb64.size() != 0) begin
                    e = sb64.pop_front();
                    check_eq("q64", 128'(q64), 128'(e.q));
                    check_eq("r64", 128'(r64), 128'(e.r));
                    check_eq("dz64", 128'(dz64), 128'(e.dz));
                    if (e.y != 64'd0) begin
                        recon = 128'(q64) * 128'(e.y) + 128'(r64);
                        check_eq("ident64", 128'((recon == 128'(e.x)) && (r64 < e.y)),
                                 128'd1);
                    end
                end
            end
            if (iv64 && ordy64) begin
                e.x   = x64;
                e.y   = y64;
                e.dz  = (y64 == 64'd0);
                e.q   = (y64 == 64'd0) ? '1 : x64 / y64;
                e.r   = (y64 == 64'd0) ? x64 : x64 % y64;
                e.lat = 0;
                sb64.push_back(e);
            end
        end
    end

    // Drivers: called just after a rising edge; return just after the
    // accepting edge. Inputs are scrambled afterwards to exercise capture.
    task automatic send8(input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        while (!ordy8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check_eq("send8_timeout", 128'(n), 128'd0);
        x8 = x; y8 = y; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom);
    endtask

    task automatic send64(input logic [63:0] x, input logic [63:0] y);
        int n = 0;
        while (!ordy64 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check_eq("send64_timeout", 128'(n), 128'd0);
        x64 = x; y64 = y; iv64 = 1'b1;
        @(posedge clk); #1;
        iv64 = 1'b0; x64 = {$urandom, $urandom}; y64 = {$urandom, $urandom};
    endtask

    task automatic drain8();
        int n = 0;
        while (sb8.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check_eq("drain8", 128'(sb8.size()), 128'd0);
    endtask

    task automatic drain64();
        int n = 0;
        while (sb64.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check_eq("drain64", 128'(sb64.size()), 128'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rx, ry;
        logic [7:0]  bq, br;
        int          n;

        rst_n = 1'b0;
        iv8 = 1'b0; x8 = '0; y8 = '0; rdy8 = 1'b1;
        iv64 = 1'b0; x64 = '0; y64 = '0; rdy64 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready8", 128'(ordy8), 128'd1);
        check_eq("rst_valid8", 128'(ov8), 128'd0);
        check_eq("rst_q8", 128'(q8), 128'd0);
        check_eq("rst_r8", 128'(r8), 128'd0);
        check_eq("rst_dz8", 128'(dz8), 128'd0);
        check_eq("rst_ready64", 128'(ordy64), 128'd1);
        check_eq("rst_valid64", 128'(ov64), 128'd0);
        rst_n = 1'b1;

        // Directed 8-bit cases; the first is accepted on the first edge
        // after reset release.
        send8(8'd100, 8'd7);   drain8();
        send8(8'd255, 8'd1);   drain8();
        send8(8'd5,   8'd200); drain8();
        send8(8'd0,   8'd3);   drain8();
        send8(8'd7,   8'd0);   drain8();
        send8(8'd128, 8'd255); drain8();
        send8(8'd255, 8'd128); drain8();

        // Backpressure: hold the result for 5 cycles while a competing
        // request is offered.
        rdy8 = 1'b0;
        send8(8'd123, 8'd10);
        n = 0;
        while (!ov8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("bp_reach_done", 128'(ov8), 128'd1);
        bq = 8'd123 / 8'd10;
        br = 8'd123 % 8'd10;
        for (int i = 0; i < 5; i++) begin
            iv8 = 1'b1; x8 = 8'd1; y8 = 8'd1;
            @(posedge clk); #1;
            check_eq("bp_valid", 128'(ov8), 128'd1);
            check_eq("bp_ready", 128'(ordy8), 128'd0);
            check_eq("bp_q", 128'(q8), 128'(bq));
            check_eq("bp_r", 128'(r8), 128'(br));
            check_eq("bp_dz", 128'(dz8), 128'd0);
        end
        iv8 = 1'b0;
        rdy8 = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release_ready", 128'(ordy8), 128'd1);
        check_eq("bp_release_valid", 128'(ov8), 128'd0);
        repeat (12) @(posedge clk);
        #1;
        check_eq("bp_no_phantom", 128'(ov8), 128'd0);
        check_eq("bp_queue", 128'(sb8.size()), 128'd0);

        // Reset in the middle of BUSY aborts the request.
        send8(8'd100, 8'd7);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_ready", 128'(ordy8), 128'd1);
        check_eq("abort_valid", 128'(ov8), 128'd0);
        check_eq("abort_q", 128'(q8), 128'd0);
        check_eq("abort_r", 128'(r8), 128'd0);
        sb8.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send8(8'd200, 8'd9);
        drain8();

        // Random 64-bit requests, issued back to back.
        for (int i = 0; i < N_RAND; i++) begin
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom};
            case (i % 4)
                0: ry = ry | 64'h8000_0000_0000_0000;
                1: ;
                2: ry = ry >> $urandom_range(63, 1);
                default: rx = rx >> $urandom_range(63, 1);
            endcase
            if (i % 97 == 5) ry = 64'd0;
            if (i == 1) begin rx = '1; ry = '1; end
            if (i == 2) begin rx = '1; ry = 64'h8000_0000_0000_0000; end
            if (i == 3) begin rx = 64'd0; ry = 64'd12345; end
            send64(rx, ry);
        end
        drain64();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
